// File: rtl/nova_ddr_scrb_ctl_if.sv
// AXI4 write-channel bundle (AW, W, B) between the DDR scrubber and the DDR controller.
// The master modport is the scrubber side; the slave modport is the memory side.
interface nova_ddr_scrb_ctl_if #(
  parameter int unsigned ID_W = 16
) ();
  logic [ID_W-1:0] awid;
  logic [63:0]     awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            awvalid;
  logic            awready;

  logic [511:0]    wdata;
  logic [63:0]     wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;

  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/nova_ddr_scrb_ctl.sv
// DDR scrubber: writes full AXI4 bursts over [0, MAX_ADDR] with bounded outstanding bursts.
// Define NOVA_DDR_SCRB_PATTERN_EN to tag each 64-bit wdata lane with its beat byte address.
module nova_ddr_scrb_ctl #(
  parameter logic [63:0] MAX_ADDR         = 64'h3FFFFFFFF,
  parameter int unsigned BURST_LEN_MINUS1 = 15,
  parameter int unsigned MAX_OUTSTANDING  = 8,
  parameter int unsigned ID_W             = 16
) (
  input  logic                clk_main_a0,
  input  logic                rst_main_n,
  input  logic                start_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic [63:0]         cur_addr_o,
  nova_ddr_scrb_ctl_if.master axi_io
);

  localparam logic [63:0] BurstBytes = 64'(BURST_LEN_MINUS1 + 1) * 64'd64;
  localparam logic [63:0] NumBursts  = (MAX_ADDR + 64'd1) / BurstBytes;
  localparam logic [63:0] LastAddr   = MAX_ADDR + 64'd1 - BurstBytes;
  localparam int unsigned OutW       = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OutW-1:0] MaxOut = OutW'(MAX_OUTSTANDING);
  localparam logic [7:0]  LastBeat   = 8'(BURST_LEN_MINUS1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e          state_q;
  logic            busy_q, done_q, err_q;
  logic            awvalid_q, wvalid_q, wlast_q;
  logic [63:0]     cur_addr_q, w_addr_q;
  logic [63:0]     aw_issued_q, w_bursts_q;
  logic [OutW-1:0] outst_q;
  logic [7:0]      beat_q;
  logic [511:0]    wdata_q;

  logic            aw_hs, w_hs, wlast_hs, b_hs, last_aw;
  logic [63:0]     cur_addr_d, w_addr_d, aw_issued_d, w_bursts_d;
  logic [OutW-1:0] outst_d;
  logic [7:0]      beat_d;
  logic [511:0]    wdata_d;

  // Counter values after this cycle's handshakes; registered valids are derived from these
  // so they never depend combinationally on ready.
  always_comb begin
    aw_hs       = awvalid_q & axi_io.awready;
    w_hs        = wvalid_q & axi_io.wready;
    wlast_hs    = w_hs & wlast_q;
    b_hs        = busy_q & axi_io.bvalid;
    last_aw     = aw_hs & (cur_addr_q == LastAddr);
    aw_issued_d = aw_hs ? aw_issued_q + 64'd1 : aw_issued_q;
    cur_addr_d  = aw_hs ? cur_addr_q + BurstBytes : cur_addr_q;
    w_bursts_d  = wlast_hs ? w_bursts_q + 64'd1 : w_bursts_q;
    w_addr_d    = wlast_hs ? w_addr_q + BurstBytes : w_addr_q;
    beat_d      = beat_q;
    if (w_hs) beat_d = wlast_q ? 8'd0 : beat_q + 8'd1;
    outst_d = outst_q;
    if (aw_hs && !b_hs) begin
      outst_d = outst_q + OutW'(1);
    end else if (!aw_hs && b_hs) begin
      outst_d = outst_q - OutW'(1);
    end
  end

`ifdef NOVA_DDR_SCRB_PATTERN_EN
  assign wdata_d = {8{w_addr_d + (64'(beat_d) << 6)}};
`else
  assign wdata_d = '0;
`endif

  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      state_q     <= StIdle;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      wlast_q     <= 1'b0;
      cur_addr_q  <= '0;
      w_addr_q    <= '0;
      aw_issued_q <= '0;
      w_bursts_q  <= '0;
      outst_q     <= '0;
      beat_q      <= '0;
      wdata_q     <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q     <= StRun;
            busy_q      <= 1'b1;
            err_q       <= 1'b0;
            awvalid_q   <= 1'b1;
            wvalid_q    <= 1'b0;
            wlast_q     <= (LastBeat == 8'd0);
            cur_addr_q  <= '0;
            w_addr_q    <= '0;
            aw_issued_q <= '0;
            w_bursts_q  <= '0;
            outst_q     <= '0;
            beat_q      <= '0;
            wdata_q     <= '0;
          end
        end
        StRun, StDrain: begin
          cur_addr_q  <= cur_addr_d;
          w_addr_q    <= w_addr_d;
          aw_issued_q <= aw_issued_d;
          w_bursts_q  <= w_bursts_d;
          outst_q     <= outst_d;
          beat_q      <= beat_d;
          wdata_q     <= wdata_d;
          wlast_q     <= (beat_d == LastBeat);
          if (b_hs && (axi_io.bresp != 2'b00)) err_q <= 1'b1;
          awvalid_q <= (state_q == StRun) && !last_aw && (outst_d < MaxOut) &&
                       (aw_issued_d < NumBursts);
          // W for burst n only once burst n has been accepted on AW.
          wvalid_q  <= (w_bursts_d < aw_issued_d);
          if (state_q == StRun && last_aw) state_q <= StDrain;
          if (state_q == StDrain && w_bursts_d == NumBursts && outst_d == '0) begin
            state_q   <= StDone;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            wlast_q   <= 1'b0;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  logic unused_bid;
  assign unused_bid = ^axi_io.bid;

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign err_o          = err_q;
  assign cur_addr_o     = cur_addr_q;
  assign axi_io.awid    = ID_W'(0);
  assign axi_io.awaddr  = cur_addr_q;
  assign axi_io.awlen   = LastBeat;
  assign axi_io.awsize  = 3'b110;
  assign axi_io.awburst = 2'b01;
  assign axi_io.awvalid = awvalid_q;
  assign axi_io.wdata   = wdata_q;
  assign axi_io.wstrb   = '1;
  assign axi_io.wlast   = wlast_q;
  assign axi_io.wvalid  = wvalid_q;
  assign axi_io.bready  = busy_q;

endmodule

// File: doc/nova_ddr_scrb_ctl.md
# nova_ddr_scrb_ctl

DDR scrubber/initializer for the CL-attached DDR AXI4 port. After power-up or on software request it sequences full-burst AXI4 writes over the whole DDR address range, which puts the ECC and the data in a known state. It keeps a bounded number of bursts in flight and reports progress and errors. It sits between the shell DDR-C write channels and the CL datapath, and it owns those channels only while `busy` is high.

## Interface
- `MAX_ADDR`, 64'h3FFFFFFFF: last byte address scrubbed (16 GB). Simulation builds use 64'h1FFF. (MAX_ADDR+1) must be a multiple of burst bytes.
- `BURST_LEN_MINUS1`, 15: AXI awlen value. Burst bytes = (BURST_LEN_MINUS1+1)*64.
- `MAX_OUTSTANDING`, 8: maximum number of AW bursts issued but not yet answered on B. Range 1..255.
- `ID_W`, 16: AXI ID width.

Ports:
- `clk_main_a0`  in  1  clock.
- `rst_main_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle pulse that begins a scrub. Ignored while `busy`.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse when the final B response is received.
- `err`  out  1  sticky, set by any bresp != 2'b00. Cleared by the next accepted `start`.
- `cur_addr`  out  64  awaddr of the next burst to issue.
- `awid`  out  ID_W  constant 0.
- `awaddr`  out  64  burst byte address.
- `awlen`  out  8  = BURST_LEN_MINUS1.
- `awsize`  out  3  constant 3'b110.
- `awburst`  out  2  constant 2'b01.
- `awvalid`  out  1  address valid.
- `awready`  in  1  address ready.
- `wdata`  out  512  write data.
- `wstrb`  out  64  all ones.
- `wlast`  out  1  high on the last beat of each burst.
- `wvalid`  out  1  data valid.
- `wready`  in  1  data ready.
- `bid`  in  ID_W  ignored.
- `bresp`  in  2  write response.
- `bvalid`  in  1  response valid.
- `bready`  out  1  high whenever `busy`.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE to RUN on `start`. `cur_addr` loads 0, `err` clears, all counters clear.
  - RUN: issue AW whenever `outstanding < MAX_OUTSTANDING` and not all bursts have been issued. `cur_addr` advances by the burst byte count on each AW handshake.
  - RUN to DRAIN on the AW handshake whose address equals MAX_ADDR+1 minus the burst byte count.
  - DRAIN to DONE once the last W beat has been sent and `outstanding == 0`.
  - DONE to IDLE unconditionally after one cycle.
- Counters:
  - `aw_issued`: bursts issued on AW.
  - `w_bursts`: bursts fully sent on W.
  - `outstanding`: incremented on an AW handshake, decremented on a B handshake. On a same-cycle AW and B handshake it is unchanged. Width is clog2(MAX_OUTSTANDING+1).
- W ordering: W beats for burst n start only when `aw_issued > n`, so W never leads AW. A beat counter runs 0..BURST_LEN_MINUS1 and wraps to 0 on the wlast handshake.
- The AW and W channels are independent. An AW handshake and a W handshake in the same cycle are both counted.
- Any bresp of SLVERR or DECERR sets `err`. The scrub continues to completion.
- Reset mid-operation: all state returns to IDLE, all valids drop, and in-flight responses are abandoned. The shell is reset together with this block.

## Timing
- Reset values: `busy`, `done`, `err`, `awvalid`, `wvalid`, `wlast`, `bready` are 0. `cur_addr`, `awaddr`, `wdata` are 0.
- `awvalid` asserts on the first cycle after `start`. The first `wvalid` asserts no earlier than the cycle after the first AW handshake.
- Throughput: one AW per cycle and one W beat per cycle when ready is held high. Steady state is one burst per BURST_LEN_MINUS1+1 cycles.
- Valid/ready rules: once asserted, `awvalid` and `wvalid` hold, with stable payload, until their handshake. Valids never depend combinationally on ready.
- `done` pulses in the cycle after the final B handshake. `busy` falls in that same cycle.

## Configuration
- `NOVA_DDR_SCRB_PATTERN_EN`
  - Defined: each 64-bit lane of `wdata` carries the byte address of its beat (awaddr + beat*64), repeated 8 times. This makes the data address-tagged so later read checks can detect it.
  - Undefined: `wdata` is all zeros.

## Test plan
- Basic run, MAX_ADDR=0x1FFF, ready signals held high, bresp OKAY. Pulse `start`. Required: 8 AW with awaddr 0x0, 0x400, ... 0x1C00; 128 W beats with wlast on every 16th; one `done` pulse; `err`=0.
- Backpressure: hold bvalid low until 8 bursts have been issued. Required: no 9th AW while `outstanding`=8. Releasing one B allows exactly one more AW.
- Error: return SLVERR on burst 3. Required: `err`=1 after that response, all 8 bursts still complete, `done` pulses, and the next `start` clears `err`.
- Random ready: randomize awready and wready. Required: W never leads AW, payload is stable while valid and not ready, and 128 beats are sent in total.
- Reset mid-scrub: assert `rst_main_n`=0 after 3 AW handshakes. Required: all outputs return to reset values, and a new `start` begins again at awaddr 0.
- With `NOVA_DDR_SCRB_PATTERN_EN` defined: beat 1 of the burst at 0x400 has every 64-bit lane equal to 0x440.
